// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin arbiter sharing one I2C master between NREQ
// requesters. One single-byte read/write command is issued per grant and
// the read byte plus ACK/NACK status is returned to the granted requester.
//
// Optional feature macro: I2C_ARB_TIMEOUT_EN
//   defined   -> 16-bit watchdog over ISSUE/WAIT; expiry completes the
//                transaction with err=1 and pulses abort to the master.
//   undefined -> no watchdog; abort is constant 0.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req/req_rw/req_addr/
//   req_wdata                per-requester request level and fields
//   gnt, done                one-hot grant, one-cycle completion pulse
//   rdata, err               returned read byte and NACK/timeout flag
//   cmd_*                    command channel to the I2C master
//   rsp_*                    completion strobe and data from the master
//   abort                    one-cycle master reset on watchdog expiry
module i2c_arbiter #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_rw,
    input  logic [7*NREQ-1:0] req_addr,
    input  logic [8*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [7:0]        rdata,
    output logic              err,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_rw,
    output logic [6:0]        cmd_addr,
    output logic [7:0]        cmd_wdata,
    input  logic              rsp_valid,
    input  logic [7:0]        rsp_rdata,
    input  logic              rsp_nack,
    output logic              abort
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic [IW-1:0] last;
    logic [IW-1:0] sel_idx;
    logic          sel_found;
    logic          tmo_hit;

    // Round-robin pick: first set req bit searching upward from last+1,
    // wrapping. Starting at offset 1 makes the previous winner lowest
    // priority, which gives the fairness on immediate re-request.
    always_comb begin
        logic [IW-1:0] k;
        sel_found = 1'b0;
        sel_idx   = '0;
        k         = '0;
        for (int i = 1; i <= NREQ; i++) begin
            k = IW'((int'(last) + i) % NREQ);
            if (!sel_found && req[k]) begin
                sel_found = 1'b1;
                sel_idx   = k;
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    assign tmo_hit = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst)
            tmo_cnt <= '0;
        else if (state == S_IDLE && sel_found)
            tmo_cnt <= '0;
        else if (state == S_ISSUE || state == S_WAIT)
            tmo_cnt <= tmo_cnt + 16'd1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign cmd_valid = (state == S_ISSUE);
    // gnt is still the one-hot of idx while in DONE.
    assign done      = (state == S_DONE) ? gnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            gnt       <= '0;
            idx       <= '0;
            last      <= IW'(NREQ - 1);
            cmd_rw    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            rdata     <= '0;
            err       <= 1'b0;
            abort     <= 1'b0;
        end else begin
            abort <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sel_found) begin
                        idx       <= sel_idx;
                        gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
                        cmd_rw    <= req_rw[sel_idx];
                        cmd_addr  <= req_addr[int'(sel_idx)*7 +: 7];
                        cmd_wdata <= req_wdata[int'(sel_idx)*8 +: 8];
                        state     <= S_ISSUE;
                    end
                end
                // Handshakes are tested before the watchdog so a
                // coincident handshake wins.
                S_ISSUE: begin
                    if (cmd_ready) begin
                        state <= S_WAIT;
                    end else if (tmo_hit) begin
                        err   <= 1'b1;
                        abort <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_WAIT: begin
                    if (rsp_valid) begin
                        if (cmd_rw)
                            rdata <= rsp_rdata;
                        err   <= rsp_nack;
                        state <= S_DONE;
                    end else if (tmo_hit) begin
                        err   <= 1'b1;
                        abort <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    last  <= idx;
                    gnt   <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Testbench for i2c_arbiter (NREQ=4, TIMEOUT_CYCLES=16). The bench acts as
// both the requesters and the I2C master; expected grants come from a
// round-robin pick over the pending set, expected rdata from the last read.
module tb_i2c_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, req_rw;
    logic [27:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  gnt, done;
    logic [7:0]  rdata;
    logic        err, cmd_valid, cmd_ready, cmd_rw;
    logic [6:0]  cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_nack;
    logic        abort;

    i2c_arbiter #(.NREQ(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .err(err),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .abort(abort)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference state
    int         last_m;
    logic [7:0] rd_m;
    logic       f_rw [4];
    logic [6:0] f_a  [4];
    logic [7:0] f_w  [4];

    function automatic int pick(input logic [3:0] r, input int lst);
        for (int i = 1; i <= 4; i++) begin
            int k;
            k = (lst + i) % 4;
            if (((r >> k) & 4'd1) != 4'd0) return k;
        end
        return -1;
    endfunction

    function automatic logic [3:0] oh(input int i);
        logic [3:0] v;
        v = 4'd1 << i;
        return v;
    endfunction

    task automatic set_req(input int i, input logic rw, input logic [6:0] a, input logic [7:0] w);
        f_rw[i] = rw; f_a[i] = a; f_w[i] = w;
        req_rw[i] = rw;
        req_addr[7*i +: 7] = a;
        req_wdata[8*i +: 8] = w;
        req[i] = 1'b1;
    endtask

    // Wait for cmd_valid (bounded); returns at the negedge where it is seen.
    task automatic wait_cmd(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (cmd_valid) begin ok = 1'b1; break; end
        end
    endtask

    // Master side: accept after rdly cycles, respond after vdly cycles.
    // spur drives stray rsp_valid in ISSUE and stray cmd_ready in WAIT.
    // Returns at the negedge of the done cycle.
    task automatic finish(input int rdly, input int vdly, input bit spur,
                          input logic [7:0] rd, input logic nk);
        repeat (rdly) begin
            rsp_valid = spur; rsp_rdata = ~rd; rsp_nack = ~nk;
            @(negedge clk);
        end
        rsp_valid = 1'b0; cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        repeat (vdly) begin
            cmd_ready = spur;
            @(negedge clk);
        end
        cmd_ready = 1'b0; rsp_valid = 1'b1; rsp_rdata = rd; rsp_nack = nk;
        @(negedge clk);
        rsp_valid = 1'b0; rsp_rdata = 8'h00; rsp_nack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_m = 3;
        rd_m = 8'h00;
    endtask

    task automatic test_reset();
        req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
        cmd_ready = 0; rsp_valid = 0; rsp_rdata = 0; rsp_nack = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (gnt !== 4'b0) begin bad++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
        total++; if (done !== 4'b0) begin bad++; $display("FAIL rst_done: got %b want 0000", done); end
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL rst_cmd_valid: got %b want 0", cmd_valid); end
        total++; if (abort !== 1'b0) begin bad++; $display("FAIL rst_abort: got %b want 0", abort); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err); end
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL rst_rdata: got %h want 00", rdata); end
        rst = 1'b0;
        last_m = 3; rd_m = 8'h00;
    endtask

    task automatic test_single_write();
        bit ok;
        set_req(2, 1'b0, 7'h52, 8'h3C);
        wait_cmd(ok);
        total++; if (!ok) begin bad++; $display("FAIL wr_cmd_valid: got none want cmd_valid"); end
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL wr_gnt: got %b want 0100", gnt); end
        total++; if (cmd_addr !== 7'h52 || cmd_wdata !== 8'h3C || cmd_rw !== 1'b0) begin
            bad++; $display("FAIL wr_cmd: got %h/%h/%b want 52/3c/0", cmd_addr, cmd_wdata, cmd_rw); end
        finish(2, 1, 1'b1, 8'h77, 1'b0);
        total++; if (done !== 4'b0100) begin bad++; $display("FAIL wr_done: got %b want 0100", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL wr_err: got %b want 0", err); end
        total++; if (rdata !== rd_m) begin bad++; $display("FAIL wr_rdata: got %h want %h", rdata, rd_m); end
        req[2] = 1'b0; last_m = 2;
        @(negedge clk);
        total++; if (done !== 4'b0 || gnt !== 4'b0) begin
            bad++; $display("FAIL wr_after: got done=%b gnt=%b want 0000/0000", done, gnt); end
    endtask

    task automatic test_read();
        bit ok;
        set_req(0, 1'b1, 7'h21, 8'h00);
        wait_cmd(ok);
        total++; if (!ok || gnt !== 4'b0001 || cmd_rw !== 1'b1) begin
            bad++; $display("FAIL rd_grant: got gnt=%b rw=%b want 0001/1", gnt, cmd_rw); end
        finish(0, 0, 1'b0, 8'hA5, 1'b0);
        rd_m = 8'hA5;
        total++; if (done !== 4'b0001) begin bad++; $display("FAIL rd_done: got %b want 0001", done); end
        total++; if (rdata !== 8'hA5) begin bad++; $display("FAIL rd_rdata: got %h want a5", rdata); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rd_err: got %b want 0", err); end
        req[0] = 1'b0; last_m = 0;
        @(negedge clk);
    endtask

    task automatic test_nack();
        bit ok;
        set_req(1, 1'b0, 7'h10, 8'h5A);
        wait_cmd(ok);
        total++; if (!ok || gnt !== 4'b0010) begin bad++; $display("FAIL nack_gnt: got %b want 0010", gnt); end
        finish(1, 2, 1'b0, 8'h3E, 1'b1);
        total++; if (done !== 4'b0010) begin bad++; $display("FAIL nack_done: got %b want 0010", done); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL nack_err: got %b want 1", err); end
        total++; if (rdata !== rd_m) begin bad++; $display("FAIL nack_rdata: got %h want %h", rdata, rd_m); end
        req[1] = 1'b0; last_m = 1;
        @(negedge clk);
        total++; if (gnt !== 4'b0 || cmd_valid !== 1'b0) begin
            bad++; $display("FAIL nack_idle: got gnt=%b cv=%b want 0000/0", gnt, cmd_valid); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int e;
        do_reset();
        for (int i = 0; i < 4; i++)
            set_req(i, 1'($urandom), 7'($urandom), 8'($urandom));
        for (int t = 0; t < 8; t++) begin
            logic [7:0] rd;
            logic nk;
            rd = 8'($urandom); nk = 1'($urandom);
            e = pick(req, last_m);
            wait_cmd(ok);
            total++; if (!ok || gnt !== oh(t % 4)) begin
                bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", t, gnt, oh(t % 4)); end
            total++; if (cmd_addr !== f_a[e] || cmd_rw !== f_rw[e] || cmd_wdata !== f_w[e]) begin
                bad++; $display("FAIL rr_cmd[%0d]: got %h/%b/%h want %h/%b/%h", t, cmd_addr, cmd_rw,
                                cmd_wdata, f_a[e], f_rw[e], f_w[e]); end
            finish(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0, rd, nk);
            if (f_rw[e]) rd_m = rd;
            total++; if (done !== oh(e) || err !== nk || rdata !== rd_m) begin
                bad++; $display("FAIL rr_done[%0d]: got %b/%b/%h want %b/%b/%h", t, done, err, rdata,
                                oh(e), nk, rd_m); end
            last_m = e;
            if (t == 7) req = '0;
        end
        @(negedge clk);
    endtask

    task automatic test_post_grant_change();
        bit ok;
        set_req(3, 1'b1, 7'h33, 8'h44);
        wait_cmd(ok);
        req[3] = 1'b0; req_rw[3] = 1'b0; req_addr[27:21] = 7'h7F; req_wdata[31:24] = 8'hEE;
        @(negedge clk);
        total++; if (!ok || cmd_valid !== 1'b1 || cmd_addr !== 7'h33 || cmd_rw !== 1'b1 || cmd_wdata !== 8'h44) begin
            bad++; $display("FAIL pg_cmd: got %b %h/%b/%h want 1 33/1/44", cmd_valid, cmd_addr, cmd_rw, cmd_wdata); end
        finish(0, 0, 1'b0, 8'h9C, 1'b0);
        rd_m = 8'h9C;
        total++; if (done !== 4'b1000 || rdata !== 8'h9C) begin
            bad++; $display("FAIL pg_done: got %b/%h want 1000/9c", done, rdata); end
        last_m = 3;
        @(negedge clk);
    endtask

    task automatic test_random();
        bit ok;
        int e;
        req = 4'($urandom_range(1, 15));
        for (int i = 0; i < 4; i++)
            if (req[i]) set_req(i, 1'($urandom), 7'($urandom), 8'($urandom));
        for (int t = 0; t < 40; t++) begin
            logic [7:0] rd;
            logic nk;
            rd = 8'($urandom); nk = 1'($urandom);
            e = pick(req, last_m);
            wait_cmd(ok);
            total++; if (!ok || gnt !== oh(e)) begin
                bad++; $display("FAIL rnd_gnt[%0d]: got %b want %b", t, gnt, oh(e)); end
            total++; if (cmd_addr !== f_a[e] || cmd_rw !== f_rw[e] || cmd_wdata !== f_w[e]) begin
                bad++; $display("FAIL rnd_cmd[%0d]: got %h/%b/%h want %h/%b/%h", t, cmd_addr, cmd_rw,
                                cmd_wdata, f_a[e], f_rw[e], f_w[e]); end
            finish(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom), rd, nk);
            if (f_rw[e]) rd_m = rd;
            total++; if (done !== oh(e) || err !== nk || rdata !== rd_m) begin
                bad++; $display("FAIL rnd_done[%0d]: got %b/%b/%h want %b/%b/%h", t, done, err, rdata,
                                oh(e), nk, rd_m); end
            last_m = e;
            // winner may re-request in its own done cycle; idle ones may join
            if ($urandom_range(0, 1) == 1) set_req(e, 1'($urandom), 7'($urandom), 8'($urandom));
            else req[e] = 1'b0;
            for (int i = 0; i < 4; i++)
                if (i != e && !req[i] && $urandom_range(0, 2) == 0)
                    set_req(i, 1'($urandom), 7'($urandom), 8'($urandom));
            if (req == 4'b0) set_req(int'($urandom_range(0, 3)), 1'($urandom), 7'($urandom), 8'($urandom));
        end
        // drain the grant already pending from the last update
        e = pick(req, last_m);
        wait_cmd(ok);
        req = '0;
        finish(0, 0, 1'b0, 8'h00, 1'b0);
        if (f_rw[e]) rd_m = 8'h00;
        last_m = e;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        set_req(3, 1'b0, 7'h45, 8'h12);
        wait_cmd(ok);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        total++; if (cmd_valid !== 1'b0 || gnt === 4'b0) begin
            bad++; $display("FAIL rm_wait: got cv=%b gnt=%b want 0/nonzero", cmd_valid, gnt); end
        set_req(1, 1'b1, 7'h0F, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        total++; if (gnt !== 4'b0 || cmd_valid !== 1'b0 || done !== 4'b0) begin
            bad++; $display("FAIL rm_rst: got gnt=%b cv=%b done=%b want 0000/0/0000", gnt, cmd_valid, done); end
        rst = 1'b0; last_m = 3; rd_m = 8'h00;
        wait_cmd(ok);
        total++; if (!ok || gnt !== 4'b0010) begin bad++; $display("FAIL rm_first: got %b want 0010", gnt); end
        finish(0, 1, 1'b0, 8'h61, 1'b0);
        rd_m = 8'h61;
        total++; if (done !== 4'b0010 || rdata !== 8'h61) begin
            bad++; $display("FAIL rm_done: got %b/%h want 0010/61", done, rdata); end
        req[1] = 1'b0; last_m = 1;
        wait_cmd(ok);
        total++; if (!ok || gnt !== 4'b1000) begin bad++; $display("FAIL rm_second: got %b want 1000", gnt); end
        req[3] = 1'b0;
        finish(0, 0, 1'b0, 8'h00, 1'b0);
        last_m = 3;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        set_req(0, 1'b1, 7'h2A, 8'h00);
        wait_cmd(ok);
`ifdef I2C_ARB_TIMEOUT_EN
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n++;
            if (done !== 4'b0) break;
        end
        req[0] = 1'b0;
        total++; if (n != 16) begin bad++; $display("FAIL to_latency: got %0d want 16", n); end
        total++; if (done !== 4'b0001 || err !== 1'b1 || abort !== 1'b1 || rdata !== rd_m) begin
            bad++; $display("FAIL to_done: got %b/%b/%b/%h want 0001/1/1/%h", done, err, abort, rdata, rd_m); end
        @(negedge clk);
        total++; if (abort !== 1'b0) begin bad++; $display("FAIL to_abort_pulse: got %b want 0", abort); end
`else
        n = 0;
        repeat (1000) begin
            @(negedge clk);
            if (done !== 4'b0 || abort !== 1'b0) n++;
        end
        total++; if (n != 0) begin bad++; $display("FAIL no_to: got %0d done/abort cycles want 0", n); end
        total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL no_to_hold: got %b want 1", cmd_valid); end
        req[0] = 1'b0;
        finish(0, 0, 1'b0, 8'hC3, 1'b0);
        rd_m = 8'hC3;
        total++; if (done !== 4'b0001 || rdata !== 8'hC3) begin
            bad++; $display("FAIL no_to_done: got %b/%h want 0001/c3", done, rdata); end
`endif
        last_m = 0;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_read();
        test_nack();
        test_round_robin();
        test_post_grant_change();
        test_random();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
